// File: rtl/core_pkg.sv
// Shared constants and width helpers for the fetch queue.
package core_pkg;

   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam int          DEF_LANES = 2;
   localparam int          DEF_DEPTH = 8;
   localparam int          DEF_XLEN  = 32;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fq_lane_rotate.sv
// Maps head-relative lane k to storage index (base + k) mod 2**PTR_W.
module fq_lane_rotate #(
   parameter int LANES = 2,
   parameter int PTR_W = 3
) (
   input  logic [PTR_W-1:0]            base_i,
   output logic [LANES-1:0][PTR_W-1:0] idx_o
);

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         idx_o[k] = base_i + PTR_W'(k);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// N-lane instruction queue between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward the incoming group in the same cycle.
module fetch_queue
   import core_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DEPTH = DEF_DEPTH,
   parameter int XLEN  = DEF_XLEN
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   input  logic [LANES-1:0]           enq_mask_i,
   input  logic [LANES*XLEN-1:0]      enq_inst_i,
   input  logic [XLEN-1:0]            enq_pc_i,
   output logic                       enq_ready_o,
   output logic [LANES-1:0]           deq_valid_o,
   output logic [LANES*XLEN-1:0]      deq_inst_o,
   output logic [LANES*XLEN-1:0]      deq_pc_o,
   input  logic [$clog2(LANES+1)-1:0] deq_count_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int                PTR_W     = ptr_w(DEPTH);
   localparam int                CNT_W     = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(DEPTH - LANES);
   localparam logic [CNT_W-1:0]  LANES_C   = CNT_W'(LANES);

   logic [XLEN-1:0]             inst_q [DEPTH];
   logic [XLEN-1:0]             inst_d [DEPTH];
   logic [XLEN-1:0]             pc_q   [DEPTH];
   logic [XLEN-1:0]             pc_d   [DEPTH];
   logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic [LANES-1:0][PTR_W-1:0] rd_idx, wr_idx;
   logic [CNT_W-1:0]            enq_n, deq_n, avail, wr_skip;
   logic                        enq_fire, bypass;

   fq_lane_rotate #(.LANES(LANES), .PTR_W(PTR_W)) u_rd_rot (
      .base_i (head_q),
      .idx_o  (rd_idx)
   );

   fq_lane_rotate #(.LANES(LANES), .PTR_W(PTR_W)) u_wr_rot (
      .base_i (tail_q),
      .idx_o  (wr_idx)
   );

   // Ready looks only at registered occupancy, never at this cycle's dequeue.
   assign enq_ready_o = (count_q <= READY_MAX);
   assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
   assign count_o     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = enq_fire && (count_q == '0);
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      enq_n = '0;
      for (int k = 0; k < LANES; k++) begin
         if (enq_fire && enq_mask_i[k]) enq_n = enq_n + CNT_W'(1);
      end

      // Bypassed lanes count as available entries for the consumer.
      avail = bypass ? enq_n : count_q;
      deq_n = CNT_W'(deq_count_i);
      if (deq_n > LANES_C) deq_n = LANES_C;
      if (deq_n > avail)   deq_n = avail;
      if (flush_i)         deq_n = '0;

      wr_skip = bypass ? deq_n : '0;
      inst_d  = inst_q;
      pc_d    = pc_q;
      for (int k = 0; k < LANES; k++) begin
         if (enq_fire && enq_mask_i[k] && (CNT_W'(k) >= wr_skip)) begin
            inst_d[wr_idx[k]] = enq_inst_i[k*XLEN +: XLEN];
            pc_d[wr_idx[k]]   = enq_pc_i + XLEN'(4 * k);
         end
      end

      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= XLEN'(NOP_INST);
            pc_q[i]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      deq_valid_o = '0;
      deq_inst_o  = '0;
      deq_pc_o    = '0;
      for (int k = 0; k < LANES; k++) begin
         deq_valid_o[k]              = (count_q > CNT_W'(k));
         deq_inst_o[k*XLEN +: XLEN]  = inst_q[rd_idx[k]];
         deq_pc_o[k*XLEN +: XLEN]    = pc_q[rd_idx[k]];
      end
      if (bypass) begin
         deq_valid_o = enq_mask_i;
         for (int k = 0; k < LANES; k++) begin
            deq_inst_o[k*XLEN +: XLEN] = enq_inst_i[k*XLEN +: XLEN];
            deq_pc_o[k*XLEN +: XLEN]   = enq_pc_i + XLEN'(4 * k);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random traffic
// against a list-of-entries reference model.
module tb_fetch_queue;
   import core_pkg::*;

   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   logic                  clock_i = 1'b0;
   logic                  reset_i, flush_i, enq_valid_i, enq_ready_o;
   logic [LANES-1:0]      enq_mask_i, deq_valid_o;
   logic [LANES*XLEN-1:0] enq_inst_i, deq_inst_o, deq_pc_o;
   logic [XLEN-1:0]       enq_pc_i;
   logic [1:0]            deq_count_i;
   logic [3:0]            count_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } ent_t;

   typedef struct packed {
      int                    cnt;
      bit                    rdy;
      logic [LANES-1:0]      vld;
      logic [LANES*XLEN-1:0] inst;
      logic [LANES*XLEN-1:0] pc;
      bit                    nop;
   } exp_t;

   ent_t mq[$];
   exp_t eq[$];

   fetch_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .flush_i     (flush_i),
      .enq_valid_i (enq_valid_i),
      .enq_mask_i  (enq_mask_i),
      .enq_inst_i  (enq_inst_i),
      .enq_pc_i    (enq_pc_i),
      .enq_ready_o (enq_ready_o),
      .deq_valid_o (deq_valid_o),
      .deq_inst_o  (deq_inst_o),
      .deq_pc_o    (deq_pc_o),
      .deq_count_i (deq_count_i),
      .count_o     (count_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
      end
   endtask

   // Drive one cycle, record what the outputs must show, then advance the model.
   task automatic cycle(input bit rs, input bit fl, input bit ev, input logic [LANES-1:0] m,
                        input logic [LANES*XLEN-1:0] ins, input logic [XLEN-1:0] pc,
                        input int dq, input bit nop);
      exp_t e;
      ent_t t;
      int   sz, n, d, lim;
      bit   fire, byp;
      reset_i     = rs;
      flush_i     = fl;
      enq_valid_i = ev;
      enq_mask_i  = m;
      enq_inst_i  = ins;
      enq_pc_i    = pc;
      deq_count_i = 2'(dq);
      if (rs) mq.delete();
      sz    = mq.size();
      e     = '0;
      e.cnt = sz;
      e.rdy = (DEPTH - sz) >= LANES;
      e.nop = nop;
      n = 0;
      for (int k = 0; k < LANES; k++) if (m[k]) n++;
      fire = ev && e.rdy && !fl && !rs;
      byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = fire && (sz == 0);
`endif
      for (int k = 0; k < LANES; k++) begin
         if (byp) begin
            e.vld[k] = m[k];
            if (m[k]) begin
               e.inst[k*XLEN +: XLEN] = ins[k*XLEN +: XLEN];
               e.pc[k*XLEN +: XLEN]   = pc + XLEN'(4 * k);
            end
         end else if (k < sz) begin
            e.vld[k]               = 1'b1;
            e.inst[k*XLEN +: XLEN] = mq[k].inst;
            e.pc[k*XLEN +: XLEN]   = mq[k].pc;
         end else if (nop) begin
            e.inst[k*XLEN +: XLEN] = NOP_INST;
            e.pc[k*XLEN +: XLEN]   = '0;
         end
      end
      eq.push_back(e);
      if (rs || fl) begin
         mq.delete();
      end else begin
         lim = byp ? n : sz;
         d = dq;
         if (d > LANES) d = LANES;
         if (d > lim) d = lim;
         if (!byp) repeat (d) t = mq.pop_front();
         if (fire) begin
            for (int k = (byp ? d : 0); k < n; k++) begin
               t.inst = ins[k*XLEN +: XLEN];
               t.pc   = pc + XLEN'(4 * k);
               mq.push_back(t);
            end
         end
      end
      @(posedge clock_i);
      #1;
   endtask

   task automatic grp(input logic [LANES-1:0] m, input logic [XLEN-1:0] pc, input int dq);
      cycle(1'b0, 1'b0, 1'b1, m, {$urandom, $urandom}, pc, dq, 1'b0);
   endtask

   task automatic deq(input int dq);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, dq, 1'b0);
   endtask

   // Monitor: compare every presented output against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock_i);
         if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("count_o", 64'(count_o), 64'(e.cnt));
            chk("enq_ready_o", 64'(enq_ready_o), 64'(e.rdy));
            chk("deq_valid_o", 64'(deq_valid_o), 64'(e.vld));
            for (int k = 0; k < LANES; k++) begin
               if (e.vld[k] || e.nop) begin
                  chk($sformatf("deq_inst[%0d]", k), 64'(deq_inst_o[k*XLEN +: XLEN]),
                      64'(e.inst[k*XLEN +: XLEN]));
                  chk($sformatf("deq_pc[%0d]", k), 64'(deq_pc_o[k*XLEN +: XLEN]),
                      64'(e.pc[k*XLEN +: XLEN]));
               end
            end
         end
      end
   end

   initial begin
      bit               rs, fl, ev;
      logic [LANES-1:0] m;
      reset_i     = 1'b1;
      flush_i     = 1'b0;
      enq_valid_i = 1'b0;
      enq_mask_i  = '0;
      enq_inst_i  = '0;
      enq_pc_i    = '0;
      deq_count_i = '0;
      @(posedge clock_i);
      #1;

      // Reset, then idle with NOP storage visible.
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 1'b1);

      // Dual enqueue, partial dequeue.
      cycle(1'b0, 1'b0, 1'b1, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h100, 0, 1'b0);
      deq(1);
      deq(0);
      deq(2);

      // Fill to full, fifth group ignored, drain in order.
      for (int i = 0; i < 5; i++) grp(2'b11, 32'h200 + 32'(8 * i), 0);
      for (int i = 0; i < 5; i++) deq(2);

      // Sustained enqueue/dequeue across pointer wrap.
      for (int i = 0; i < 20; i++) grp(2'b11, 32'h1000 + 32'(8 * i), 2);
      deq(2);
      deq(2);

      // Flush with concurrent enqueue and dequeue.
      grp(2'b11, 32'h300, 0);
      grp(2'b11, 32'h308, 0);
      grp(2'b01, 32'h310, 0);
      cycle(1'b0, 1'b1, 1'b1, 2'b11, {$urandom, $urandom}, 32'h400, 2, 1'b0);
      deq(0);

      // Clamping and single-lane groups.
      grp(2'b01, 32'h500, 0);
      deq(2);
      deq(2);
      grp(2'b01, 32'h504, 0);
      deq(3);

      // Random traffic including flushes and mid-run resets.
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 59) == 0);
         fl = !rs && ($urandom_range(0, 19) == 0);
         ev = !rs && ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 2))
            0:       m = 2'b00;
            1:       m = 2'b01;
            default: m = 2'b11;
         endcase
         cycle(rs, fl, ev, m, {$urandom, $urandom}, $urandom & 32'hFFFF_FFFC,
               int'($urandom_range(0, 3)), rs);
      end
      deq(0);

      @(negedge clock_i);
      #1;
      chk("scoreboard_drained", 64'(eq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
